x7seg_capture: RTL and testbench

- Receive-side counterpart of the multiplexed 4-digit 7-segment driver.
- Samples the active-low segment bus, digit-enable bus and decimal-point line, then debounces each digit slot.
- Decodes segment patterns back to hex nibbles and reassembles the 16-bit displayed value.
- Used for on-board loopback self-test and for reading panel contents from a neighbouring board.

---
 rtl/x7seg_capture.sv | 187 ++++++++++++++++++
 tb/tb_x7seg_capture.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/x7seg_capture.sv
// Receive-side capture for a multiplexed, active-low 4-digit 7-segment bus.
// Debounces each digit slot, decodes the segments to hex and rebuilds the 16-bit value.
module x7seg_capture #(
  parameter int STABLE_CYC = 16,
  parameter int TIMEOUT    = 2000000,
  parameter int TO_W       = 21
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic [6:0]  smg_duan,
  input  logic [3:0]  smg_wei,
  input  logic        dp,
  output logic [15:0] value,
  output logic [3:0]  dp_mask,
  output logic        frame_vld,
  output logic        seg_err,
  output logic        wei_err,
  output logic        stale
);

  localparam int              CNT_W    = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYC - 1);
  localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT);
  localparam logic [TO_W-1:0]  TO_PRE   = TO_W'(TIMEOUT - 1);

  localparam logic [1:0] ST_WAIT   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_HELD   = 2'd2;

  // Sample layout: {wei[3:0], duan[6:0], dp}
  logic [11:0] sync_a;
  logic [11:0] sync_s;
  logic [11:0] samp;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;

  logic [15:0]     nib_buf;
  logic [3:0]      dp_buf;
  logic [3:0]      mask;
  logic [TO_W-1:0] to_cnt;

  logic       changed;
  logic       eval_now;
  logic [1:0] dig_k;
  logic       one_hot;
  logic       multi;
  logic       dec_valid;
  logic [3:0] dec_nib;
  logic       capture;

  // Segment pattern to {valid, nibble}.
  function automatic logic [4:0] decode(input logic [6:0] d);
    logic [4:0] r;
    case (d)
      7'b0000001: r = 5'h10;
      7'b1001111: r = 5'h11;
      7'b0010010: r = 5'h12;
      7'b0000110: r = 5'h13;
      7'b1001100: r = 5'h14;
      7'b0100100: r = 5'h15;
      7'b0100000: r = 5'h16;
      7'b0001111: r = 5'h17;
      7'b0000000: r = 5'h18;
      7'b0000100: r = 5'h19;
      7'b0001000: r = 5'h1A;
      7'b1100000: r = 5'h1B;
      7'b0110001: r = 5'h1C;
      7'b1000010: r = 5'h1D;
      7'b0110000: r = 5'h1E;
      7'b0111000: r = 5'h1F;
      default:    r = 5'h00;
    endcase
    return r;
  endfunction

  // Synchronisers reset to the idle (all-high) bus so a blank bus after reset is not a change.
  // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sync_a <= '1;
      sync_s <= '1;
    end else begin
      sync_a <= {smg_wei, smg_duan, dp};
      sync_s <= sync_a;
    end
  end

  assign changed  = (sync_s != samp);
  assign eval_now = (state == ST_SETTLE) && !changed && (cnt == CNT_LAST);
  assign {dec_valid, dec_nib} = decode(samp[7:1]);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    dig_k   = 2'd0;
    one_hot = 1'b0;
    multi   = 1'b0;
    case (samp[11:8])
      4'b1110: begin dig_k = 2'd0; one_hot = 1'b1; end
      4'b1101: begin dig_k = 2'd1; one_hot = 1'b1; end
      4'b1011: begin dig_k = 2'd2; one_hot = 1'b1; end
      4'b0111: begin dig_k = 2'd3; one_hot = 1'b1; end
      4'b1111: ;
      default: multi = 1'b1;
    endcase
  end

  assign capture = eval_now && one_hot && dec_valid;

  // Debounce FSM: each stable period is evaluated once, on the last SETTLE cycle.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state <= ST_WAIT;
      cnt   <= '0;
      samp  <= '1;
    end else begin
      case (state)
        ST_WAIT, ST_HELD: begin
          if (changed) begin
            samp  <= sync_s;
            cnt   <= '0;
            state <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (changed) begin
            samp <= sync_s;
            cnt  <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= ST_HELD;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= ST_WAIT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      seg_err <= 1'b0;
      wei_err <= 1'b0;
      nib_buf <= '0;
      dp_buf  <= '0;
    end else begin
      seg_err <= eval_now && one_hot && !dec_valid;
      wei_err <= eval_now && multi;
      if (capture) begin
        nib_buf[{dig_k, 2'b00} +: 4] <= dec_nib;
        dp_buf[dig_k]                <= ~samp[0];
      end
    end
  end

  // Frame assembly and timeout; a capture beats a simultaneous timeout hit.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      value     <= '0;
      dp_mask   <= '0;
      frame_vld <= 1'b0;
      mask      <= '0;
      to_cnt    <= '0;
      stale     <= 1'b1;
    end else begin
      frame_vld <= 1'b0;
      if (mask == 4'hF) begin
        value     <= nib_buf;
        dp_mask   <= dp_buf;
        frame_vld <= 1'b1;
        mask      <= '0;
      end
      if (capture) begin
        mask[dig_k] <= 1'b1;
        to_cnt      <= '0;
        stale       <= 1'b0;
      end else if (to_cnt == TO_PRE) begin
        to_cnt <= TO_MAX;
        stale  <= 1'b1;
        mask   <= '0;
      end else if (to_cnt != TO_MAX) begin
        to_cnt <= to_cnt + TO_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_x7seg_capture.sv
// Directed bench for x7seg_capture: scans, glitches, decode/enable errors, timeout, mid-frame reset.
module tb_x7seg_capture;

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic [6:0]  smg_duan = 7'h7F;
  logic [3:0]  smg_wei = 4'hF;
  logic        dp = 1'b1;
  logic [15:0] value;
  logic [3:0]  dp_mask;
  logic        frame_vld;
  logic        seg_err;
  logic        wei_err;
  logic        stale;

  int errors = 0;
  int checks = 0;
  int n_frame = 0;
  int n_seg = 0;
  int n_wei = 0;
  int cyc = 0;
  int last_frame_cyc = 0;

  x7seg_capture #(.STABLE_CYC(16), .TIMEOUT(200), .TO_W(8)) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .smg_duan  (smg_duan),
    .smg_wei   (smg_wei),
    .dp        (dp),
    .value     (value),
    .dp_mask   (dp_mask),
    .frame_vld (frame_vld),
    .seg_err   (seg_err),
    .wei_err   (wei_err),
    .stale     (stale)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_vld) begin
      n_frame++;
      last_frame_cyc = cyc;
    end
    if (seg_err) n_seg++;
    if (wei_err) n_wei++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got=running required=finished");
    $fatal(1);
  end

  function automatic logic [6:0] enc(input logic [3:0] n);
    logic [6:0] r;
    case (n)
      4'h0: r = 7'b0000001;  4'h1: r = 7'b1001111;
      4'h2: r = 7'b0010010;  4'h3: r = 7'b0000110;
      4'h4: r = 7'b1001100;  4'h5: r = 7'b0100100;
      4'h6: r = 7'b0100000;  4'h7: r = 7'b0001111;
      4'h8: r = 7'b0000000;  4'h9: r = 7'b0000100;
      4'hA: r = 7'b0001000;  4'hB: r = 7'b1100000;
      4'hC: r = 7'b0110001;  4'hD: r = 7'b1000010;
      4'hE: r = 7'b0110000;  default: r = 7'b0111000;
    endcase
    return r;
  endfunction

  task automatic drive(input logic [3:0] wei, input logic [6:0] duan, input logic dpl,
                       input int cycles);
    smg_wei  = wei;
    smg_duan = duan;
    dp       = dpl;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic digit(input int k, input logic [3:0] nib, input logic dp_on, input int cycles);
    logic [3:0] sel;
    sel = 4'b0001 << k;
    drive(~sel, enc(nib), ~dp_on, cycles);
  endtask

  task automatic scan(input logic [15:0] x, input logic [3:0] dpm);
    for (int k = 0; k < 4; k++) digit(k, x[4*k +: 4], dpm[k], 32);
  endtask

  task automatic test_reset();
    clr_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (value !== 16'h0) begin errors++; $display("FAIL reset_value got=%h exp=0000", value); end
    checks++; if (dp_mask !== 4'h0) begin errors++; $display("FAIL reset_dp_mask got=%b exp=0000", dp_mask); end
    checks++; if (frame_vld !== 1'b0) begin errors++; $display("FAIL reset_frame_vld got=%b exp=0", frame_vld); end
    checks++; if (seg_err !== 1'b0) begin errors++; $display("FAIL reset_seg_err got=%b exp=0", seg_err); end
    checks++; if (wei_err !== 1'b0) begin errors++; $display("FAIL reset_wei_err got=%b exp=0", wei_err); end
    checks++; if (stale !== 1'b1) begin errors++; $display("FAIL reset_stale got=%b exp=1", stale); end
    clr_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_scan();
    int f0, s0, w0;
    f0 = n_frame; s0 = n_seg; w0 = n_wei;
    scan(16'h12AF, 4'b0100);
    scan(16'h12AF, 4'b0100);
    checks++; if (n_frame - f0 !== 2) begin errors++; $display("FAIL scan_frames got=%0d exp=2", n_frame - f0); end
    checks++; if (value !== 16'h12AF) begin errors++; $display("FAIL scan_value got=%h exp=12af", value); end
    checks++; if (dp_mask !== 4'b0100) begin errors++; $display("FAIL scan_dp_mask got=%b exp=0100", dp_mask); end
    checks++; if (n_seg - s0 !== 0) begin errors++; $display("FAIL scan_seg_err got=%0d exp=0", n_seg - s0); end
    checks++; if (n_wei - w0 !== 0) begin errors++; $display("FAIL scan_wei_err got=%0d exp=0", n_wei - w0); end
    checks++; if (stale !== 1'b0) begin errors++; $display("FAIL scan_stale got=%b exp=0", stale); end
  endtask

  task automatic test_glitch();
    int f0;
    f0 = n_frame;
    digit(0, 4'hF, 1'b0, 32);
    digit(1, 4'hA, 1'b0, 12);
    drive(4'b1101, 7'b0000000, 1'b1, 10);
    digit(1, 4'hA, 1'b0, 32);
    digit(2, 4'h2, 1'b1, 32);
    digit(3, 4'h1, 1'b0, 32);
    checks++; if (n_frame - f0 !== 1) begin errors++; $display("FAIL glitch10_frames got=%0d exp=1", n_frame - f0); end
    checks++; if (value !== 16'h12AF) begin errors++; $display("FAIL glitch10_value got=%h exp=12af", value); end
    f0 = n_frame;
    digit(0, 4'hF, 1'b0, 12);
    drive(4'b1110, 7'b0000000, 1'b1, 20);
    digit(1, 4'hA, 1'b0, 32);
    digit(2, 4'h2, 1'b1, 32);
    digit(3, 4'h1, 1'b0, 32);
    checks++; if (n_frame - f0 !== 1) begin errors++; $display("FAIL glitch20_frames got=%0d exp=1", n_frame - f0); end
    checks++; if (value !== 16'h12A8) begin errors++; $display("FAIL glitch20_value got=%h exp=12a8", value); end
  endtask

  task automatic test_seg_err();
    int f0, s0;
    f0 = n_frame; s0 = n_seg;
    digit(0, 4'hF, 1'b0, 32);
    drive(4'b1101, 7'b1111110, 1'b1, 32);
    digit(2, 4'h2, 1'b1, 32);
    digit(3, 4'h1, 1'b0, 32);
    checks++; if (n_seg - s0 !== 1) begin errors++; $display("FAIL seg_err_pulses got=%0d exp=1", n_seg - s0); end
    checks++; if (n_frame - f0 !== 0) begin errors++; $display("FAIL seg_err_frames got=%0d exp=0", n_frame - f0); end
    digit(1, 4'hA, 1'b0, 32);
    checks++; if (n_frame - f0 !== 1) begin errors++; $display("FAIL seg_fix_frames got=%0d exp=1", n_frame - f0); end
    checks++; if (value !== 16'h12AF) begin errors++; $display("FAIL seg_fix_value got=%h exp=12af", value); end
    checks++; if (dp_mask !== 4'b0100) begin errors++; $display("FAIL seg_fix_dp_mask got=%b exp=0100", dp_mask); end
  endtask

  task automatic test_wei_err();
    int f0, s0, w0;
    f0 = n_frame; s0 = n_seg; w0 = n_wei;
    digit(0, 4'h3, 1'b0, 32);
    digit(1, 4'h4, 1'b0, 32);
    drive(4'b1100, enc(4'h5), 1'b1, 32);
    checks++; if (n_wei - w0 !== 1) begin errors++; $display("FAIL wei_err_pulses got=%0d exp=1", n_wei - w0); end
    drive(4'b1111, 7'h7F, 1'b1, 32);
    checks++; if (n_wei - w0 !== 1) begin errors++; $display("FAIL blank_wei_err got=%0d exp=1", n_wei - w0); end
    checks++; if (n_seg - s0 !== 0) begin errors++; $display("FAIL blank_seg_err got=%0d exp=0", n_seg - s0); end
    checks++; if (n_frame - f0 !== 0) begin errors++; $display("FAIL wei_err_frames got=%0d exp=0", n_frame - f0); end
    digit(2, 4'h5, 1'b0, 32);
    digit(3, 4'h6, 1'b0, 32);
    checks++; if (n_frame - f0 !== 1) begin errors++; $display("FAIL wei_mask_frames got=%0d exp=1", n_frame - f0); end
    checks++; if (value !== 16'h6543) begin errors++; $display("FAIL wei_mask_value got=%h exp=6543", value); end
    checks++; if (dp_mask !== 4'b0000) begin errors++; $display("FAIL wei_mask_dp_mask got=%b exp=0000", dp_mask); end
  endtask

  task automatic test_timeout();
    int f0, fc;
    f0 = n_frame;
    scan(16'h12AF, 4'b0100);
    checks++; if (n_frame - f0 !== 1) begin errors++; $display("FAIL to_pre_frames got=%0d exp=1", n_frame - f0); end
    fc = last_frame_cyc;
    smg_wei = 4'hF; smg_duan = 7'h7F; dp = 1'b1;
    // Last capture is one edge before the frame pulse; stale rises TIMEOUT edges after it.
    while (cyc < fc + 198) @(negedge clk);
    checks++; if (stale !== 1'b0) begin errors++; $display("FAIL to_before got=%b exp=0", stale); end
    @(negedge clk);
    checks++; if (stale !== 1'b1) begin errors++; $display("FAIL to_hit got=%b exp=1", stale); end
    checks++; if (value !== 16'h12AF) begin errors++; $display("FAIL to_value_held got=%h exp=12af", value); end
    repeat (20) @(negedge clk);
    f0 = n_frame;
    digit(0, 4'hF, 1'b0, 32);
    checks++; if (stale !== 1'b0) begin errors++; $display("FAIL to_resume_stale got=%b exp=0", stale); end
    digit(1, 4'h0, 1'b0, 32);
    digit(2, 4'hF, 1'b0, 32);
    digit(3, 4'h0, 1'b0, 32);
    checks++; if (n_frame - f0 !== 1) begin errors++; $display("FAIL to_resume_frames got=%0d exp=1", n_frame - f0); end
    checks++; if (value !== 16'h0F0F) begin errors++; $display("FAIL to_resume_value got=%h exp=0f0f", value); end
    checks++; if (dp_mask !== 4'b0000) begin errors++; $display("FAIL to_resume_dp_mask got=%b exp=0000", dp_mask); end
    f0 = n_frame;
    digit(0, 4'hA, 1'b0, 32);
    drive(4'hF, 7'h7F, 1'b1, 230);
    checks++; if (stale !== 1'b1) begin errors++; $display("FAIL discard_stale got=%b exp=1", stale); end
    digit(1, 4'h0, 1'b0, 32);
    digit(2, 4'hF, 1'b0, 32);
    digit(3, 4'h0, 1'b0, 32);
    checks++; if (n_frame - f0 !== 0) begin errors++; $display("FAIL discard_frames got=%0d exp=0", n_frame - f0); end
    digit(0, 4'hF, 1'b0, 32);
    checks++; if (n_frame - f0 !== 1) begin errors++; $display("FAIL discard_fill_frames got=%0d exp=1", n_frame - f0); end
    checks++; if (value !== 16'h0F0F) begin errors++; $display("FAIL discard_value got=%h exp=0f0f", value); end
  endtask

  task automatic test_reset_mid();
    int f0;
    digit(0, 4'h1, 1'b1, 32);
    digit(1, 4'h2, 1'b0, 32);
    smg_wei = 4'hF; smg_duan = 7'h7F; dp = 1'b1;
    clr_n = 1'b0;
    #1;
    checks++; if (value !== 16'h0) begin errors++; $display("FAIL midrst_value got=%h exp=0000", value); end
    checks++; if (dp_mask !== 4'h0) begin errors++; $display("FAIL midrst_dp_mask got=%b exp=0000", dp_mask); end
    checks++; if (stale !== 1'b1) begin errors++; $display("FAIL midrst_stale got=%b exp=1", stale); end
    checks++; if ({frame_vld, seg_err, wei_err} !== 3'b000) begin
      errors++; $display("FAIL midrst_pulses got=%b exp=000", {frame_vld, seg_err, wei_err});
    end
    repeat (3) @(negedge clk);
    clr_n = 1'b1;
    repeat (2) @(negedge clk);
    f0 = n_frame;
    digit(2, 4'h3, 1'b0, 32);
    digit(3, 4'h4, 1'b0, 32);
    checks++; if (n_frame - f0 !== 0) begin errors++; $display("FAIL midrst_partial_frames got=%0d exp=0", n_frame - f0); end
    digit(0, 4'h1, 1'b1, 32);
    digit(1, 4'h2, 1'b0, 32);
    checks++; if (n_frame - f0 !== 1) begin errors++; $display("FAIL midrst_fresh_frames got=%0d exp=1", n_frame - f0); end
    checks++; if (value !== 16'h4321) begin errors++; $display("FAIL midrst_value_after got=%h exp=4321", value); end
    checks++; if (dp_mask !== 4'b0001) begin errors++; $display("FAIL midrst_dp_mask_after got=%b exp=0001", dp_mask); end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_glitch();
    test_seg_err();
    test_wei_err();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
